// File: rtl/multdiv_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the shared
// multiply/divide unit. The arbiter takes the master side.
interface multdiv_arbiter_if #(
  parameter int LatW = 6
);
  // requester side
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][1:0]       req_op;
  logic [1:0][1:0]       req_signed;
  logic [1:0][31:0]      req_a;
  logic [1:0][31:0]      req_b;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [31:0]           rsp_data;
  // unit side
  logic                  md_mult_en;
  logic                  md_div_en;
  logic                  md_mult_sel;
  logic                  md_div_sel;
  logic [1:0]            md_operator;
  logic [1:0]            md_signed_mode;
  logic [31:0]           md_op_a;
  logic [31:0]           md_op_b;
  logic                  md_ready;
  logic                  md_valid;
  logic [31:0]           md_result;
  // status
  logic                  busy;
  logic                  owner;
  logic [LatW-1:0]       last_lat;

  modport master (
    input  req_valid, req_op, req_signed, req_a, req_b, rsp_ready,
           md_valid, md_result,
    output req_ready, rsp_valid, rsp_data,
           md_mult_en, md_div_en, md_mult_sel, md_div_sel,
           md_operator, md_signed_mode, md_op_a, md_op_b, md_ready,
           busy, owner, last_lat
  );

  modport slave (
    output req_valid, req_op, req_signed, req_a, req_b, rsp_ready,
           md_valid, md_result,
    input  req_ready, rsp_valid, rsp_data,
           md_mult_en, md_div_en, md_mult_sel, md_div_sel,
           md_operator, md_signed_mode, md_op_a, md_op_b, md_ready,
           busy, owner, last_lat
  );
endinterface

// File: rtl/multdiv_arbiter.sv
// Round-robin sharing of one multi-cycle multiply/divide unit between two
// requesters. Operands are latched on grant, the unit is run until it reports
// valid, and the result is held on a valid/ready response to the owner.
module multdiv_arbiter #(
  parameter int LatW = 6
) (
  input  logic              clk,
  input  logic              rst,
  multdiv_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [LatW-1:0] LatMax = '1;

  state_e          state;
  logic            rp;        // requester that wins a tie
  logic            owner;
  logic [1:0]      op;
  logic [1:0]      sgn;
  logic [31:0]     a;
  logic [31:0]     b;
  logic [31:0]     result;
  logic [LatW-1:0] lat;
  logic [LatW-1:0] last_lat;

  logic            win;
  logic [1:0]      grant;
  logic [LatW-1:0] lat_nx;

  // Arbitration is combinational so a lone request is granted the same cycle.
  always_comb begin
    win    = (&bus.req_valid) ? rp : bus.req_valid[1];
    grant  = 2'b00;
    if (state == IDLE && (|bus.req_valid))
      grant = win ? 2'b10 : 2'b01;
    lat_nx = (lat == LatMax) ? lat : lat + 1'b1;
  end

  // Unit controls and response are decoded from registered state only.
  always_comb begin
    bus.md_mult_en  = (state == BUSY) && !op[1];
    bus.md_mult_sel = (state == BUSY) && !op[1];
    bus.md_div_en   = (state == BUSY) && op[1];
    bus.md_div_sel  = (state == BUSY) && op[1];
    bus.md_ready    = (state == BUSY);
    bus.rsp_valid   = 2'b00;
    if (state == RESP)
      bus.rsp_valid = owner ? 2'b10 : 2'b01;
  end

  assign bus.req_ready      = grant;
  assign bus.rsp_data       = result;
  assign bus.md_operator    = op;
  assign bus.md_signed_mode = sgn;
  assign bus.md_op_a        = a;
  assign bus.md_op_b        = b;
  assign bus.busy           = (state != IDLE);
  assign bus.owner          = owner;
  assign bus.last_lat       = last_lat;

  // Controller: grant/latch, run the unit, hold the response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rp       <= 1'b0;
      owner    <= 1'b0;
      op       <= '0;
      sgn      <= '0;
      a        <= '0;
      b        <= '0;
      result   <= '0;
      lat      <= '0;
      last_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            op    <= bus.req_op[win];
            sgn   <= bus.req_signed[win];
            a     <= bus.req_a[win];
            b     <= bus.req_b[win];
            owner <= win;
            rp    <= ~win;
            lat   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          lat <= lat_nx;
          if (bus.md_valid) begin
            result   <= bus.md_result;
            last_lat <= lat_nx;
            state    <= RESP;
          end
        end
        RESP: begin
          // only the owner's ready completes the response
          if (bus.rsp_ready[owner])
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_arbiter.sv
// Bench for multdiv_arbiter: a behavioural multiply/divide unit with
// programmable latency, directed scenarios and a randomized round-robin run.
module tb_multdiv_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multdiv_arbiter_if #(.LatW(6)) bus();
  multdiv_arbiter #(.LatW(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;
  int unit_lat = 1;
  int ucnt = 0;
  bit spurious = 1'b0;
  int rp_m = 0;

  logic [1:0]  o_grant;
  logic [31:0] o_data;
  logic [5:0]  o_lat;
  logic        o_owner;
  logic        o_busy_after;
  int          o_busy;
  logic [4:0]  o_en_first;
  logic [4:0]  o_en_resp;
  bit          o_stray;
  bit          o_tmo;

  // Arithmetic meaning of the four operators; division is signed only when
  // both operands are signed.
  function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] sg,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    ea = sg[0] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sg[1] ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    sa = a;
    sb = b;
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (sg == 2'b11) ? 32'(sa / sb) : a / b;
      default: return (sg == 2'b11) ? 32'(sa % sb) : a % b;
    endcase
  endfunction

  // Unit model: answers unit_lat cycles after its enables rise.
  always @(negedge clk) begin
    if ((bus.md_mult_en || bus.md_div_en) && bus.md_ready) begin
      if (ucnt == unit_lat - 1) begin
        bus.md_valid  = 1'b1;
        bus.md_result = ref_md(bus.md_operator, bus.md_signed_mode, bus.md_op_a, bus.md_op_b);
      end else begin
        bus.md_valid = 1'b0;
      end
      ucnt++;
    end else begin
      ucnt = 0;
      bus.md_valid = spurious;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operation from requester g and collect what the bench observed.
  task automatic run_op(input int g, input logic [1:0] op, input logic [1:0] sg,
                        input logic [31:0] a, input logic [31:0] b,
                        input int ulat, input int hold);
    int n;
    int h;
    h = 1 - g;
    unit_lat = ulat;
    o_stray = 0; o_tmo = 0; o_busy = 0; o_en_first = '0; o_en_resp = '0;
    bus.req_op[g] = op; bus.req_signed[g] = sg; bus.req_a[g] = a; bus.req_b[g] = b;
    bus.req_valid[g] = 1'b1;
    @(negedge clk);
    o_grant = bus.req_ready;
    n = 0;
    while (!bus.req_ready[g] && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready[g]) o_tmo = 1;
    @(posedge clk); #1;
    bus.req_valid[g] = 1'b0;
    n = 0;
    while (n < 400) begin
      @(negedge clk); n++;
      if (bus.rsp_valid[g]) break;
      if (bus.md_ready) begin
        if (o_busy == 0)
          o_en_first = {bus.md_mult_en, bus.md_mult_sel, bus.md_div_en, bus.md_div_sel, bus.md_ready};
        o_busy++;
      end
      if (bus.req_ready != 2'b00 || bus.rsp_valid != 2'b00) o_stray = 1;
    end
    if (!bus.rsp_valid[g]) begin o_tmo = 1; return; end
    o_data = bus.rsp_data;
    o_en_resp = {bus.md_mult_en, bus.md_mult_sel, bus.md_div_en, bus.md_div_sel, bus.md_ready};
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready[h] = 1'b1;
      bus.req_valid[h] = 1'b1;
      @(negedge clk);
      if (bus.rsp_valid !== 2'(1 << g) || bus.rsp_data !== o_data || bus.req_ready !== 2'b00)
        o_stray = 1;
    end
    bus.rsp_ready[h] = 1'b0;
    if (hold > 0) bus.req_valid[h] = 1'b0;
    bus.rsp_ready[g] = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready[g] = 1'b0;
    o_lat = bus.last_lat; o_owner = bus.owner; o_busy_after = bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0; bus.req_op = '0; bus.req_signed = '0;
    bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin nerr++;
      $display("FAIL reset_status: rsp_valid=%b busy=%b want 00/0", bus.rsp_valid, bus.busy); end
    nvec++; if (bus.owner !== 1'b0 || bus.last_lat !== 6'd0 || bus.rsp_data !== 32'd0) begin nerr++;
      $display("FAIL reset_regs: owner=%b last_lat=%0d data=%h want 0", bus.owner, bus.last_lat, bus.rsp_data); end
    nvec++; if ({bus.md_mult_en, bus.md_mult_sel, bus.md_div_en, bus.md_div_sel, bus.md_ready} !== 5'b0 ||
                bus.md_op_a !== 32'd0 || bus.md_op_b !== 32'd0 || bus.md_operator !== 2'd0 ||
                bus.md_signed_mode !== 2'd0) begin nerr++;
      $display("FAIL reset_md: md outputs not zero, a=%h b=%h", bus.md_op_a, bus.md_op_b); end
    nvec++; if (bus.req_ready !== 2'b00) begin nerr++;
      $display("FAIL reset_ready_idle: got %b want 00", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    nvec++; if (bus.req_ready !== 2'b01) begin nerr++;
      $display("FAIL reset_arb: got %b want 01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst = 1'b0;
    rp_m = 0;
  endtask

  task automatic test_mull();
    run_op(0, 2'd0, 2'b00, 32'd7, 32'd6, 3, 0);
    nvec++; if (o_grant !== 2'b01) begin nerr++; $display("FAIL mull_grant: got %b want 01", o_grant); end
    nvec++; if (o_en_first !== 5'b11001) begin nerr++; $display("FAIL mull_en: got %b want 11001", o_en_first); end
    nvec++; if (o_data !== 32'd42) begin nerr++; $display("FAIL mull_data: got %0d want 42", o_data); end
    nvec++; if (o_owner !== 1'b0 || o_lat !== 6'd3 || o_busy != 3) begin nerr++;
      $display("FAIL mull_lat: owner=%b lat=%0d busy=%0d want 0/3/3", o_owner, o_lat, o_busy); end
    nvec++; if (o_en_resp !== 5'b0 || o_stray || o_tmo) begin nerr++;
      $display("FAIL mull_proto: en_resp=%b stray=%0d tmo=%0d want 0", o_en_resp, o_stray, o_tmo); end
    nvec++; if (bus.md_op_a !== 32'd7 || bus.md_op_b !== 32'd6 || o_busy_after !== 1'b0) begin nerr++;
      $display("FAIL mull_hold_regs: a=%0d b=%0d busy=%b want 7/6/0", bus.md_op_a, bus.md_op_b, o_busy_after); end
    rp_m = 1;
  endtask

  task automatic test_signed_div();
    run_op(1, 2'd2, 2'b11, 32'hFFFF_FFEC, 32'd3, 5, 0);
    nvec++; if (o_grant !== 2'b10) begin nerr++; $display("FAIL sdiv_grant: got %b want 10", o_grant); end
    nvec++; if (o_data !== 32'hFFFF_FFFA) begin nerr++; $display("FAIL sdiv_data: got %h want fffffffa", o_data); end
    nvec++; if (o_en_first !== 5'b00111 || o_en_resp !== 5'b0) begin nerr++;
      $display("FAIL sdiv_sel: busy=%b resp=%b want 00111/00000", o_en_first, o_en_resp); end
    nvec++; if (bus.md_div_sel !== 1'b0) begin nerr++; $display("FAIL sdiv_sel_idle: got %b want 0", bus.md_div_sel); end
    nvec++; if (o_lat !== 6'(o_busy) || o_busy != 5 || o_owner !== 1'b1) begin nerr++;
      $display("FAIL sdiv_lat: lat=%0d busy=%0d owner=%b want 5/5/1", o_lat, o_busy, o_owner); end
    rp_m = 0;
  endtask

  task automatic test_both();
    logic [1:0] op1;
    logic [31:0] a0, b0, a1, b1;
    for (int r = 0; r < 2; r++) begin
      op1 = (r == 0) ? 2'd3 : 2'($urandom_range(0, 1));
      a0 = (r == 0) ? 32'd100 : $urandom; b0 = (r == 0) ? 32'd7 : 32'($urandom_range(1, 999));
      a1 = (r == 0) ? 32'd100 : $urandom; b1 = (r == 0) ? 32'd7 : $urandom;
      bus.req_op[1] = op1; bus.req_signed[1] = 2'b00; bus.req_a[1] = a1; bus.req_b[1] = b1;
      bus.req_valid[1] = 1'b1;
      run_op(0, 2'd2, 2'b00, a0, b0, 2, 0);
      nvec++; if (o_grant !== 2'(1 << rp_m)) begin nerr++;
        $display("FAIL both_first_grant r%0d: got %b want %b", r, o_grant, 2'(1 << rp_m)); end
      nvec++; if (o_data !== ref_md(2'd2, 2'b00, a0, b0) || (r == 0 && o_data !== 32'd14)) begin nerr++;
        $display("FAIL both_first_data r%0d: got %h want %h", r, o_data, ref_md(2'd2, 2'b00, a0, b0)); end
      rp_m = 1;
      run_op(1, op1, 2'b00, a1, b1, 4, 0);
      nvec++; if (o_grant !== 2'b10 || o_stray || o_tmo) begin nerr++;
        $display("FAIL both_second_grant r%0d: got %b stray=%0d want 10", r, o_grant, o_stray); end
      nvec++; if (o_data !== ref_md(op1, 2'b00, a1, b1) || (r == 0 && o_data !== 32'd2)) begin nerr++;
        $display("FAIL both_second_data r%0d: got %h want %h", r, o_data, ref_md(op1, 2'b00, a1, b1)); end
      rp_m = 0;
    end
  endtask

  task automatic test_hold();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    run_op(0, 2'd1, 2'b01, a, b, 2, 5);
    nvec++; if (o_stray || o_tmo) begin nerr++;
      $display("FAIL hold_stable: stray=%0d tmo=%0d want 0/0", o_stray, o_tmo); end
    nvec++; if (o_data !== ref_md(2'd1, 2'b01, a, b) || o_owner !== 1'b0 || o_busy_after !== 1'b0) begin nerr++;
      $display("FAIL hold_data: got %h owner=%b want %h owner 0", o_data, o_owner, ref_md(2'd1, 2'b01, a, b)); end
    rp_m = 1;
  endtask

  task automatic test_spurious();
    logic [5:0] keep;
    keep = bus.last_lat;
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      nvec++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.last_lat !== keep) begin nerr++;
        $display("FAIL spurious_valid: busy=%b rsp=%b lat=%0d want 0/00/%0d", bus.busy, bus.rsp_valid, bus.last_lat, keep); end
    end
    @(posedge clk); #1;
    spurious = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    unit_lat = 12;
    bus.req_op[0] = 2'd1; bus.req_signed[0] = 2'b11; bus.req_a[0] = 32'd5; bus.req_b[0] = 32'd9;
    bus.req_valid[0] = 1'b1;
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00 ||
                {bus.md_mult_en, bus.md_mult_sel, bus.md_div_en, bus.md_div_sel, bus.md_ready} !== 5'b0) begin nerr++;
      $display("FAIL rstmid_ctrl: busy=%b rsp=%b ready=%b md_ready=%b want 0", bus.busy, bus.rsp_valid, bus.req_ready, bus.md_ready); end
    nvec++; if (bus.md_op_a !== 32'd0 || bus.md_op_b !== 32'd0 || bus.md_operator !== 2'd0 ||
                bus.owner !== 1'b0 || bus.last_lat !== 6'd0 || bus.rsp_data !== 32'd0) begin nerr++;
      $display("FAIL rstmid_regs: a=%h op=%0d owner=%b lat=%0d data=%h want 0", bus.md_op_a, bus.md_operator, bus.owner, bus.last_lat, bus.rsp_data); end
    seen = 0;
    repeat (20) begin @(negedge clk); if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) seen = 1; end
    nvec++; if (seen) begin nerr++; $display("FAIL rstmid_no_rsp: got activity after abort, want none"); end
    @(posedge clk); #1;
    rp_m = 0;
    run_op(0, 2'd1, 2'b11, 32'h8000_0000, 32'd2, 4, 0);
    nvec++; if (o_data !== 32'hFFFF_FFFF || o_grant !== 2'b01 || o_tmo) begin nerr++;
      $display("FAIL rstmid_mulh: got %h grant=%b want ffffffff 01", o_data, o_grant); end
    rp_m = 1;
  endtask

  task automatic test_saturate();
    run_op(1, 2'd0, 2'b00, 32'd3, 32'd5, 70, 0);
    nvec++; if (o_lat !== 6'd63 || o_busy != 70 || o_data !== 32'd15) begin nerr++;
      $display("FAIL sat_lat: lat=%0d busy=%0d data=%0d want 63/70/15", o_lat, o_busy, o_data); end
    rp_m = 0;
  endtask

  task automatic test_random();
    logic [1:0]  op[2], sg[2];
    logic [31:0] a[2], b[2];
    int mask, w, ul;
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 2; k++) begin
        op[k] = 2'($urandom_range(0, 3));
        sg[k] = op[k][1] ? ($urandom_range(0, 1) ? 2'b11 : 2'b00) : 2'($urandom_range(0, 3));
        a[k]  = $urandom;
        b[k]  = $urandom;
        if (b[k] == 32'd0) b[k] = 32'd1;
        if (op[k][1] && sg[k] == 2'b11 && b[k] == 32'hFFFF_FFFF) b[k] = 32'd7;
      end
      mask = $urandom_range(1, 3);
      w = (mask == 3) ? rp_m : ((mask == 2) ? 1 : 0);
      for (int s = 0; s < ((mask == 3) ? 2 : 1); s++) begin
        if (s == 0 && mask == 3) begin
          bus.req_op[1-w] = op[1-w]; bus.req_signed[1-w] = sg[1-w];
          bus.req_a[1-w] = a[1-w]; bus.req_b[1-w] = b[1-w]; bus.req_valid[1-w] = 1'b1;
        end
        ul = $urandom_range(1, 8);
        run_op(w, op[w], sg[w], a[w], b[w], ul, 0);
        nvec++; if (o_grant !== 2'(1 << w) || o_owner !== 1'(w) || o_stray || o_tmo) begin nerr++;
          $display("FAIL rand_grant it%0d: grant=%b owner=%b want %b", it, o_grant, o_owner, 2'(1 << w)); end
        nvec++; if (o_data !== ref_md(op[w], sg[w], a[w], b[w]) || o_lat !== 6'(ul)) begin nerr++;
          $display("FAIL rand_data it%0d: got %h lat=%0d want %h lat=%0d", it, o_data, o_lat, ref_md(op[w], sg[w], a[w], b[w]), ul); end
        rp_m = 1 - w;
        w = 1 - w;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mull();
    test_signed_div();
    test_both();
    test_hold();
    test_spurious();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
